// File: rtl/traffic_light_pkg.sv
// Shared colour codes, phase codes, error bit positions and FSM encoding
// for the traffic light monitor and its per-axis checkers.
package traffic_light_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        PH_ALL_RED   = 3'd0,
        PH_NS_GREEN  = 3'd1,
        PH_NS_YELLOW = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_INVALID   = 3'd7
    } phase_e;

    localparam int ERR_W        = 5;
    localparam int ERR_ENCODING = 0;
    localparam int ERR_PAIR     = 1;
    localparam int ERR_CONFLICT = 2;
    localparam int ERR_SEQUENCE = 3;
    localparam int ERR_TIMING   = 4;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_SYNC = 2'd1,
        MON_RUN  = 2'd2
    } mon_state_e;

    function automatic logic is_valid_light(input logic [2:0] c);
        return (c == LIGHT_RED) || (c == LIGHT_YELLOW) || (c == LIGHT_GREEN);
    endfunction

    function automatic logic is_legal_change(input logic [2:0] from_c, input logic [2:0] to_c);
        return ((from_c == LIGHT_GREEN)  && (to_c == LIGHT_YELLOW)) ||
               ((from_c == LIGHT_YELLOW) && (to_c == LIGHT_RED))    ||
               ((from_c == LIGHT_RED)    && (to_c == LIGHT_GREEN));
    endfunction

    // Only meaningful once encoding, pair and conflict checks are clean.
    function automatic phase_e decode_phase(input logic [2:0] n, input logic [2:0] e);
        if (n == LIGHT_RED    && e == LIGHT_RED)    return PH_ALL_RED;
        if (n == LIGHT_GREEN  && e == LIGHT_RED)    return PH_NS_GREEN;
        if (n == LIGHT_YELLOW && e == LIGHT_RED)    return PH_NS_YELLOW;
        if (n == LIGHT_RED    && e == LIGHT_GREEN)  return PH_EW_GREEN;
        if (n == LIGHT_RED    && e == LIGHT_YELLOW) return PH_EW_YELLOW;
        return PH_INVALID;
    endfunction

endpackage

// File: rtl/light_axis_checker.sv
// Tracks one axis colour: previous colour, dwell counter, and the
// sequence/timing checks made whenever the colour changes or a yellow overstays.
module light_axis_checker
    import traffic_light_pkg::*;
#(
    parameter int GREEN_MIN_CYC  = 10,
    parameter int YELLOW_MIN_CYC = 3,
    parameter int YELLOW_MAX_CYC = 5,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       check_en,
    input  logic       seed,
    input  logic [2:0] colour,
    output logic       seq_err,
    output logic       timing_err,
    output logic       red_to_green
);

    localparam logic [CNT_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0] GMIN_C    = CNT_W'(GREEN_MIN_CYC);
    localparam logic [CNT_W-1:0] YMIN_C    = CNT_W'(YELLOW_MIN_CYC);
    localparam logic [CNT_W-1:0] YMAX_C    = CNT_W'(YELLOW_MAX_CYC);

    logic [2:0]       p_colour_q, p_colour_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] dwell_inc;

    assign dwell_inc = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_colour_q <= '0;
            dwell_q    <= '0;
        end else begin
            p_colour_q <= p_colour_d;
            dwell_q    <= dwell_d;
        end
    end

    always_comb begin
        p_colour_d   = p_colour_q;
        dwell_d      = dwell_q;
        seq_err      = 1'b0;
        timing_err   = 1'b0;
        red_to_green = 1'b0;
        if (seed) begin
            p_colour_d = colour;
            dwell_d    = CNT_W'(1);
        end else if (check_en) begin
            if (colour == p_colour_q) begin
                dwell_d = dwell_inc;
                // Fires only on the step to YELLOW_MAX_CYC+1, so once per interval.
                timing_err = (p_colour_q == LIGHT_YELLOW) && (dwell_q == YMAX_C) &&
                             (dwell_q != DWELL_MAX);
            end else begin
                seq_err      = !is_legal_change(p_colour_q, colour);
                timing_err   = ((p_colour_q == LIGHT_GREEN)  && (dwell_q < GMIN_C)) ||
                               ((p_colour_q == LIGHT_YELLOW) && (dwell_q < YMIN_C));
                red_to_green = (p_colour_q == LIGHT_RED) && (colour == LIGHT_GREEN);
                p_colour_d   = colour;
                dwell_d      = CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the intersection light buses: samples the lights,
// decodes the phase and reports encoding, pair, conflict, sequence and timing faults.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int GREEN_MIN_CYC  = 10,
    parameter int YELLOW_MIN_CYC = 3,
    parameter int YELLOW_MAX_CYC = 5,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mon_en,
    input  logic [2:0]  light_N,
    input  logic [2:0]  light_S,
    input  logic [2:0]  light_E,
    input  logic [2:0]  light_W,
    input  logic        err_clr,
    output logic [2:0]  phase,
    output logic [4:0]  err_flags,
    output logic [4:0]  err_sticky,
    output logic        fault,
    output logic [15:0] cycle_count
);

    logic [2:0]       s_n_q, s_s_q, s_e_q, s_w_q;
    mon_state_e       state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [ERR_W-1:0] flags_q, flags_d, sticky_q, sticky_d;
    logic             fault_q;
    logic [15:0]      count_q, count_d;
    logic             enc_err, pair_err, conflict_err, check_en, seed;
    logic             ns_seq, ns_tim, ns_r2g, ew_seq, ew_tim;
    logic             ew_red_to_green_unused;

    // Stage 1: light sample registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_n_q <= '0;
            s_s_q <= '0;
            s_e_q <= '0;
            s_w_q <= '0;
        end else begin
            s_n_q <= light_N;
            s_s_q <= light_S;
            s_e_q <= light_E;
            s_w_q <= light_W;
        end
    end

    assign enc_err      = !is_valid_light(s_n_q) || !is_valid_light(s_s_q) ||
                          !is_valid_light(s_e_q) || !is_valid_light(s_w_q);
    assign pair_err     = (s_n_q != s_s_q) || (s_e_q != s_w_q);
    assign conflict_err = ((s_n_q != LIGHT_RED) || (s_s_q != LIGHT_RED)) &&
                          ((s_e_q != LIGHT_RED) || (s_w_q != LIGHT_RED));
    assign check_en     = (state_q == MON_RUN) && !enc_err && !pair_err;
    assign seed         = (state_q == MON_SYNC) && !enc_err && !pair_err && !conflict_err;

    light_axis_checker #(
        .GREEN_MIN_CYC(GREEN_MIN_CYC), .YELLOW_MIN_CYC(YELLOW_MIN_CYC),
        .YELLOW_MAX_CYC(YELLOW_MAX_CYC), .CNT_W(CNT_W)
    ) u_ns (
        .clk(clk), .rst(rst), .check_en(check_en), .seed(seed), .colour(s_n_q),
        .seq_err(ns_seq), .timing_err(ns_tim), .red_to_green(ns_r2g)
    );

    // The EW axis does not feed the cycle counter.
    light_axis_checker #(
        .GREEN_MIN_CYC(GREEN_MIN_CYC), .YELLOW_MIN_CYC(YELLOW_MIN_CYC),
        .YELLOW_MAX_CYC(YELLOW_MAX_CYC), .CNT_W(CNT_W)
    ) u_ew (
        .clk(clk), .rst(rst), .check_en(check_en), .seed(seed), .colour(s_e_q),
        .seq_err(ew_seq), .timing_err(ew_tim), .red_to_green(ew_red_to_green_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= MON_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        flags_d = '0;
        unique case (state_q)
            MON_IDLE: state_d = MON_SYNC;
            MON_SYNC: if (seed) state_d = MON_RUN;
            MON_RUN:  if (enc_err || pair_err) state_d = MON_SYNC;
            default:  state_d = MON_IDLE;
        endcase
        if (!mon_en) state_d = MON_IDLE;
        if (state_q != MON_IDLE) begin
            flags_d[ERR_ENCODING] = enc_err;
            flags_d[ERR_PAIR]     = pair_err;
            flags_d[ERR_CONFLICT] = conflict_err;
            flags_d[ERR_SEQUENCE] = ns_seq | ew_seq;
            flags_d[ERR_TIMING]   = ns_tim | ew_tim;
        end
        phase_d  = (enc_err || pair_err || conflict_err) ? PH_INVALID : decode_phase(s_n_q, s_e_q);
        sticky_d = (sticky_q & ~{ERR_W{err_clr}}) | flags_d;
        count_d  = count_q + {15'd0, ns_r2g};
    end

    // Stage 2: registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            flags_q  <= '0;
            sticky_q <= '0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            fault_q  <= |sticky_d;
            count_q  <= count_d;
        end
    end

    assign phase       = phase_q;
    assign err_flags   = flags_q;
    assign err_sticky  = sticky_q;
    assign fault       = fault_q;
    assign cycle_count = count_q;

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the far end of the traffic_lights_system light buses. It consumes light_N/S/E/W and does not drive them.
- Decodes the current intersection phase and flags any unsafe or illegal light behaviour: conflicting greens, bad encodings, N/S or E/W pair mismatch, illegal colour sequences, and green/yellow dwell-time violations.
- Instantiated beside the controller in system benches and on the board for a fault LED and debug capture.

Parameters:
- GREEN_MIN_CYC, 10, minimum consecutive samples a green must hold before leaving.
- YELLOW_MIN_CYC, 3, minimum consecutive yellow samples.
- YELLOW_MAX_CYC, 5, maximum consecutive yellow samples. Must be ≥ YELLOW_MIN_CYC.
- CNT_W, 16, dwell-counter width. Counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mon_en  in  1  checking enable. Low forces FSM to IDLE.
- light_N  in  3  north light, {red,yellow,green}, one-hot.
- light_S  in  3  south light, same encoding.
- light_E  in  3  east light, same encoding.
- light_W  in  3  west light, same encoding.
- err_clr  in  1  single-cycle pulse that clears err_sticky.
- phase  out  3  decoded phase: 0 ALL_RED, 1 NS_GREEN, 2 NS_YELLOW, 3 EW_GREEN, 4 EW_YELLOW, 7 INVALID.
- err_flags  out  5  per-cycle error pulses. Bit 0 ENCODING, 1 PAIR, 2 CONFLICT, 3 SEQUENCE, 4 TIMING.
- err_sticky  out  5  OR-accumulated err_flags.
- fault  out  1  OR of err_sticky.
- cycle_count  out  16  completed NS red→green entries; wraps 65535→0.

Behaviour:
- Reset: one clock (clk); asynchronous active-high reset (rst). While rst=1: all outputs 0, phase=0, FSM IDLE, all sample registers and counters cleared.
- Pipeline:
  - Stage 1 registers the four inputs (s_*) and holds the previous sample (p_*).
  - Stage 2 registers all outputs.
  - An input change set up before edge k is reflected in outputs after edge k+1 (2-cycle latency).
- Combinational checks on s_*:
  - ENCODING: any light not in {100,010,001}.
  - PAIR: N≠S or E≠W.
  - CONFLICT: (N or S non-red) and (E or W non-red).
  - Checked in SYNC and RUN.
- Phase decode uses N and E. If ENCODING, PAIR or CONFLICT is active, phase=7.
- Monitor FSM (IDLE, SYNC, RUN):
  - IDLE: no checks, err_flags=0. mon_en=1 → SYNC.
  - SYNC: a sample with no ENCODING/PAIR/CONFLICT → RUN. That sample seeds p_* and the dwell counters; no sequence check is made on it.
  - RUN: all five checks active. Any ENCODING or PAIR error → SYNC, with sequence/timing suspended until resync. CONFLICT stays in RUN.
  - mon_en=0 in any state → IDLE next edge. err_sticky is retained.
- Per-axis checks (NS from N, EW from E), RUN only:
  - Legal transitions: hold, green→yellow, yellow→red, red→green. Any other change pulses SEQUENCE.
  - Dwell counter is 1 on the first sample of a new colour and increments per held sample, saturating.
  - On exit from green with dwell < GREEN_MIN_CYC: TIMING.
  - On exit from yellow with dwell < YELLOW_MIN_CYC: TIMING.
  - While yellow, on the sample where dwell becomes YELLOW_MAX_CYC+1: TIMING, exactly once per yellow interval.
  - Timing checks apply to illegal exits as well.
- cycle_count increments on each NS red→green transition in RUN only.
- err_sticky:
  - Next value = (err_sticky & ~{5{err_clr}}) | err_flags_next.
  - A new error in the same cycle as err_clr remains set.
- Simultaneous errors: all applicable flag bits pulse in the same cycle.

Decomposition:
- traffic_light_pkg holds:
  - colour constants LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001;
  - phase codes;
  - error bit indices;
  - FSM state encoding.
- Sub-module light_axis_checker, instantiated twice (NS, EW), contains:
  - previous-colour register, dwell counter, sequence check, timing check;
  - inputs: clk, rst, check_en, seed, colour;
  - outputs: seq_err, timing_err, red_to_green.

Test Plan (bench params GREEN_MIN=4, YELLOW_MIN=2, YELLOW_MAX=3):
- Legal loop: NS green ×4, NS yellow ×2, all red ×1, EW green ×4, EW yellow ×3, all red, NS green. Expect phase 1,2,0,3,4,0,1 two cycles after each change, err_sticky=0, cycle_count=1 after the second NS green.
- Conflict: all four lights 001. Expect err_flags[2]=1 and phase=7 two cycles later, err_sticky[2]=1, fault=1, FSM stays RUN.
- Encoding: light_N=011 for one cycle, then legal NS green held. Expect err_flags[0] pulse and err_flags[1] pulse, no SEQUENCE on resync, cycle_count unchanged.
- Sequence: NS green ×5 then NS red. Expect err_flags[3] single pulse and err_flags[4]=0.
- Yellow overrun: NS yellow ×5. Expect err_flags[4] one pulse, on the 4th yellow sample +1 cycle; no further pulses.
- Clear/reset:
  - err_clr coincident with a new CONFLICT pulse: err_sticky[2] remains 1.
  - err_clr alone: err_sticky=0.
  - rst asserted mid-yellow: all outputs 0 immediately, before the next clk edge.
